// File: rtl/alu_writeback_pkg.sv
// Shared constants for the ALU datapath: ALU op codes, branch condition
// codes and the bit positions of the architectural flags.
package alu_writeback_pkg;

    // ALU operation encodings used by the producer side of the result interface
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_CMP = 4'd7
    } alu_op_e;

    // Branch condition codes evaluated against the committed flags
    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_CS = 4'd3,
        COND_CC = 4'd4,
        COND_MI = 4'd5,
        COND_PL = 4'd6,
        COND_VS = 4'd7,
        COND_VC = 4'd8,
        COND_PE = 4'd9,
        COND_PO = 4'd10,
        COND_GT = 4'd11,
        COND_GE = 4'd12,
        COND_LT = 4'd13,
        COND_LE = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    // Flag vector layout {P,V,C,N,Z}, bit 0 = Z
    localparam int FLAGS_W = 5;
    localparam int FLAG_Z  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 2;
    localparam int FLAG_V  = 3;
    localparam int FLAG_P  = 4;

endpackage

// File: rtl/alu_writeback_wb_fifo.sv
// Small synchronous FIFO holding {dst, result} pairs between the ALU and the
// register-file write port. The head entry is read straight from registered
// storage so the write port outputs never glitch while waiting for ready.
module wb_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_pushOk;
    logic             w_popOk;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_pushOk = i_push && !o_full;
    assign w_popOk  = i_pop && !o_empty;
    assign o_data   = r_mem[r_rdPtr];

    // Storage write; entries are cleared on reset so an empty FIFO presents zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_pushOk) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_popOk) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_pushOk, w_popOk})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: accepts ALU results, commits flags, buffers register writes
// in wb_fifo and drains them over a valid/ready port, and evaluates branch
// conditions. Optional macro ALU_WB_FLAG_BYPASS_EN forwards the incoming
// flags into the condition evaluation during an accepting flags update.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic              in_wb_en,
    input  logic              in_flags_we,
    input  logic              in_zero,
    input  logic              in_negative,
    input  logic              in_carry,
    input  logic              in_overflow,
    input  logic              in_parity,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [4:0]        flags,
    input  logic [3:0]        cond,
    output logic              cond_true
);

    localparam int ENTRY_W = DATA_W + ADDR_W;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic [FLAGS_W-1:0] w_inFlags;
    logic [FLAGS_W-1:0] w_evalFlags;
    logic               w_condTrue;
    logic               w_nEqV;
    logic [FLAGS_W-1:0] r_flags;

    assign in_ready = !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && in_wb_en;
    assign wr_valid = !w_empty;
    assign w_pop    = wr_valid && wr_ready;
    assign wr_addr  = w_head[ENTRY_W-1:DATA_W];
    assign wr_data  = w_head[DATA_W-1:0];
    assign flags    = r_flags;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({in_dst, in_result}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Pack the incoming ALU flags into the architectural {P,V,C,N,Z} layout
    always_comb begin
        w_inFlags         = '0;
        w_inFlags[FLAG_Z] = in_zero;
        w_inFlags[FLAG_N] = in_negative;
        w_inFlags[FLAG_C] = in_carry;
        w_inFlags[FLAG_V] = in_overflow;
        w_inFlags[FLAG_P] = in_parity;
    end

    // Architectural flags register, updated only on an accepted flags write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_accept && in_flags_we) begin
            r_flags <= w_inFlags;
        end
    end

`ifdef ALU_WB_FLAG_BYPASS_EN
    assign w_evalFlags = (w_accept && in_flags_we) ? w_inFlags : r_flags;
`else
    assign w_evalFlags = r_flags;
`endif

    assign w_nEqV = w_evalFlags[FLAG_N] ^ w_evalFlags[FLAG_V];

    // Branch condition evaluation against the selected flag vector
    always_comb begin
        w_condTrue = 1'b0;
        case (cond)
            COND_AL: w_condTrue = 1'b1;
            COND_EQ: w_condTrue = w_evalFlags[FLAG_Z];
            COND_NE: w_condTrue = !w_evalFlags[FLAG_Z];
            COND_CS: w_condTrue = w_evalFlags[FLAG_C];
            COND_CC: w_condTrue = !w_evalFlags[FLAG_C];
            COND_MI: w_condTrue = w_evalFlags[FLAG_N];
            COND_PL: w_condTrue = !w_evalFlags[FLAG_N];
            COND_VS: w_condTrue = w_evalFlags[FLAG_V];
            COND_VC: w_condTrue = !w_evalFlags[FLAG_V];
            COND_PE: w_condTrue = w_evalFlags[FLAG_P];
            COND_PO: w_condTrue = !w_evalFlags[FLAG_P];
            COND_GT: w_condTrue = !w_evalFlags[FLAG_Z] && !w_nEqV;
            COND_GE: w_condTrue = !w_nEqV;
            COND_LT: w_condTrue = w_nEqV;
            COND_LE: w_condTrue = w_evalFlags[FLAG_Z] || w_nEqV;
            COND_NV: w_condTrue = 1'b0;
            default: w_condTrue = 1'b0;
        endcase
    end

    assign cond_true = w_condTrue;

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Consumer end of the ALU result interface: captures the ALU result and flags.
- Commits the flags to an architectural flags register.
- Buffers result and destination pairs in a small FIFO, then drains them to the register-file write port over a valid/ready handshake.
- Evaluates branch condition codes against the committed flags. Sits between the ALU output and the register file / branch unit.

Parameters:
- DATA_W, 8, width of ALU result and write data
- ADDR_W, 3, register-file address width
- DEPTH, 2, result FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  block can accept a result
- in_result  in  DATA_W  ALU out
- in_dst  in  ADDR_W  destination register
- in_wb_en  in  1  result must be written (0 = compare-only, flags only)
- in_flags_we  in  1  update flags register on accept
- in_zero, in_negative, in_carry, in_overflow, in_parity  in  1 each  ALU flags
- wr_valid  out  1  register-file write pending
- wr_ready  in  1  register file accepts write
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- flags  out  5  committed flags {P,V,C,N,Z}, bit0 = Z
- cond  in  4  condition code to evaluate
- cond_true  out  1  condition result

Behaviour:
- Reset (async, rst_n low):
  - FIFO empty; wr_valid=0, wr_addr=0, wr_data=0.
  - flags=5'b00000; in_ready=1.
  - Reset mid-operation discards all buffered entries.
- Accept on in_valid && in_ready (rising clk):
  - if in_flags_we, flags <= {P,V,C,N,Z} from inputs, visible next cycle;
  - if in_wb_en, push {in_dst,in_result} into FIFO;
  - in_wb_en=0 with in_flags_we=1 is legal (compare); both 0 is a no-op accept.
- in_ready = (count != DEPTH). Registered-count based; no same-cycle pass-through when full, even if a pop occurs that cycle.
- Drain:
  - wr_valid = (count != 0); wr_addr/wr_data come from the FIFO head, registered storage.
  - Pop on wr_valid && wr_ready.
  - wr_valid/addr/data hold stable while wr_ready=0.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, order preserved.
- Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
- Latency: first result appears on wr_* one cycle after accept; throughput 1 per cycle with wr_ready=1.
- cond_true is combinational from the flags register and cond:
  - 0 AL=1
  - 1 EQ=Z, 2 NE=!Z
  - 3 CS=C, 4 CC=!C
  - 5 MI=N, 6 PL=!N
  - 7 VS=V, 8 VC=!V
  - 9 PE=P, 10 PO=!P
  - 11 GT=!Z&&(N==V), 12 GE=(N==V)
  - 13 LT=(N!=V), 14 LE=Z||(N!=V)
  - 15 NV=0

Optional Feature:
- Macro: ALU_WB_FLAG_BYPASS_EN.
- Defined: cond_true evaluates against the incoming flags when in_valid && in_ready && in_flags_we in the same cycle (forwarding); otherwise against the flags register.
- Undefined: cond_true uses the flags register only, one cycle after accept. The flags register update is identical in both builds.

Decomposition:
- Shared constants file alongside the ALU op codes holds:
  - condition code constants COND_AL..COND_NV;
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3, FLAG_P=4.
- One sub-module: wb_fifo (parameterised DATA_W+ADDR_W wide, DEPTH deep, count/full/empty).
- Condition evaluation stays inline in alu_writeback.

Test Plan:
- Reset, then accept result=8'd10, dst=3, wb_en=1, flags_we=1, Z=0, wr_ready=1 -> next cycle wr_valid=1, wr_addr=3, wr_data=10, flags=0; following cycle wr_valid=0.
- Accept 5-5 result=0 with Z=1, flags_we=1, wb_en=0 -> no write; cond=1 gives 1 and cond=2 gives 0 one cycle later (same cycle with ALU_WB_FLAG_BYPASS_EN).
- wr_ready=0, push 8'hAA, 8'hBB -> in_ready=0 after two accepts; third in_valid held. Raise wr_ready -> AA then BB drained in order, in_ready returns 1.
- Continuous in_valid with wr_ready=1 for 8 results 1..8 -> 8 writes, consecutive cycles, in order, no drops.
- Flags N=1, V=0 -> cond 13 gives 1, cond 12 gives 0, cond 11 gives 0. Flags N=1, V=1, Z=0 -> cond 11 gives 1. Cond 0 gives 1 and cond 15 gives 0 always.
- Assert rst_n=0 with 2 entries buffered -> wr_valid=0, flags=0 immediately (asynchronously), in_ready=1.
